// File: rtl/display_timing_gen.sv
// ============================================================================
// Module   : display_timing_gen
// Purpose  : Raster timing generator with pipeline-aligned sync/DE/colour out.
// Revision : 1.0
// ============================================================================
`default_nettype none

module display_timing_gen #(
    parameter int   H_ACTIVE = 1280,
    parameter int   H_FP     = 48,
    parameter int   H_SYNC   = 112,
    parameter int   H_BP     = 248,
    parameter int   V_ACTIVE = 1024,
    parameter int   V_FP     = 1,
    parameter int   V_SYNC   = 3,
    parameter int   V_BP     = 38,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1,
    parameter int   PIPE     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    output logic [10:0] x,
    output logic [9:0]  y,
    output logic        valid,
    output logic        vsync,
    output logic        frame_start,
    input  logic [7:0]  r_in,
    input  logic [7:0]  g_in,
    input  logic [7:0]  b_in,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        de_out,
    output logic [7:0]  r_out,
    output logic [7:0]  g_out,
    output logic [7:0]  b_out
);

    localparam logic [10:0] c_H_LAST = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] c_V_LAST = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [10:0] c_H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] c_V_ACT  = 11'(V_ACTIVE);
    localparam logic [10:0] c_HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] c_HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] c_VS_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] c_VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic        c_HS_OFF = ~HS_POL;
    localparam logic        c_VS_OFF = ~VS_POL;

    logic [10:0]     r_h;
    logic [10:0]     r_v;
    logic            r_hs;
    logic            r_vs;
    logic [PIPE-1:0] r_hs_pipe;
    logic [PIPE-1:0] r_vs_pipe;
    logic [PIPE-1:0] r_de_pipe;

    logic [10:0]     w_h_nxt;
    logic [10:0]     w_v_nxt;
    logic            w_valid_nxt;
    logic            w_hs_nxt;
    logic            w_vs_nxt;
    logic            w_hs_d;
    logic            w_vs_d;
    logic            w_de_d;

    // Outputs are decoded from the next counter values so that every registered
    // output describes the position the counters hold after the same edge.
    always_comb begin
        w_h_nxt = (r_h == c_H_LAST) ? 11'd0 : r_h + 11'd1;
        w_v_nxt = r_v;
        if (r_h == c_H_LAST) begin
            w_v_nxt = (r_v == c_V_LAST) ? 11'd0 : r_v + 11'd1;
        end
        w_valid_nxt = (w_h_nxt < c_H_ACT) && (w_v_nxt < c_V_ACT);
        w_hs_nxt    = (w_h_nxt >= c_HS_BEG) && (w_h_nxt < c_HS_END);
        w_vs_nxt    = (w_v_nxt >= c_VS_BEG) && (w_v_nxt < c_VS_END);
    end

    assign w_hs_d = r_hs_pipe[PIPE-1];
    assign w_vs_d = r_vs_pipe[PIPE-1];
    assign w_de_d = r_de_pipe[PIPE-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_h         <= c_H_LAST;
            r_v         <= c_V_LAST;
            x           <= '0;
            y           <= '0;
            valid       <= 1'b0;
            frame_start <= 1'b0;
            r_hs        <= 1'b0;
            r_vs        <= 1'b0;
            vsync       <= c_VS_OFF;
        end else if (pix_en) begin
            r_h         <= w_h_nxt;
            r_v         <= w_v_nxt;
            x           <= w_valid_nxt ? w_h_nxt : 11'd0;
            y           <= w_valid_nxt ? w_v_nxt[9:0] : 10'd0;
            valid       <= w_valid_nxt;
            frame_start <= (w_h_nxt == 11'd0) && (w_v_nxt == 11'd0);
            r_hs        <= w_hs_nxt;
            r_vs        <= w_vs_nxt;
            vsync       <= w_vs_nxt ? VS_POL : c_VS_OFF;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hs_pipe <= '0;
            r_vs_pipe <= '0;
            r_de_pipe <= '0;
        end else if (pix_en) begin
            r_hs_pipe[0] <= r_hs;
            r_vs_pipe[0] <= r_vs;
            r_de_pipe[0] <= valid;
            for (int i = 1; i < PIPE; i++) begin
                r_hs_pipe[i] <= r_hs_pipe[i-1];
                r_vs_pipe[i] <= r_vs_pipe[i-1];
                r_de_pipe[i] <= r_de_pipe[i-1];
            end
        end
    end

    // Polarity is applied only here; everything upstream is active-high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hsync_out <= c_HS_OFF;
            vsync_out <= c_VS_OFF;
            de_out    <= 1'b0;
            r_out     <= '0;
            g_out     <= '0;
            b_out     <= '0;
        end else if (pix_en) begin
            hsync_out <= w_hs_d ? HS_POL : c_HS_OFF;
            vsync_out <= w_vs_d ? VS_POL : c_VS_OFF;
            de_out    <= w_de_d;
            {r_out, g_out, b_out} <= w_de_d ? {r_in, g_in, b_in} : 24'd0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_display_timing_gen.sv
// ============================================================================
// Module   : tb_display_timing_gen
// Purpose  : Directed checks of display_timing_gen (default and reduced timing).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_display_timing_gen;

    logic clk = 1'b0;
    logic reset;
    logic pix_en;

    always #5 clk = ~clk;

    // Default-parameter instance
    logic [10:0] d_x;
    logic [9:0]  d_y;
    logic        d_valid, d_vsync, d_fs, d_hso, d_vso, d_de;
    logic [7:0]  d_rin, d_gin, d_bin, d_r, d_g, d_b;
    logic [10:0] rd1 = '0;
    logic [10:0] rd2 = '0;

    // Reduced instance: H_TOTAL=13, V_TOTAL=8, frame=104, inverted syncs, PIPE=3
    logic [10:0] s_x;
    logic [9:0]  s_y;
    logic        s_valid, s_vsync, s_fs, s_hso, s_vso, s_de;
    logic [7:0]  s_r, s_g, s_b;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt_d_valid, cnt_d_hs, cnt_s_fs, cnt_s_vs;

    // Renderer model for the default instance: two enabled-cycle delay of x
    always @(posedge clk) begin
        if (pix_en) begin
            rd1 <= d_x;
            rd2 <= rd1;
        end
    end
    assign d_rin = rd2[7:0];
    assign d_gin = ~rd2[7:0];
    assign d_bin = 8'hA5;

    display_timing_gen u_def (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .x(d_x), .y(d_y), .valid(d_valid), .vsync(d_vsync), .frame_start(d_fs),
        .r_in(d_rin), .g_in(d_gin), .b_in(d_bin),
        .hsync_out(d_hso), .vsync_out(d_vso), .de_out(d_de),
        .r_out(d_r), .g_out(d_g), .b_out(d_b)
    );

    display_timing_gen #(
        .H_ACTIVE(6), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .PIPE(3)
    ) u_sml (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .x(s_x), .y(s_y), .valid(s_valid), .vsync(s_vsync), .frame_start(s_fs),
        .r_in(8'h3C), .g_in(8'h00), .b_in(8'hC3),
        .hsync_out(s_hso), .vsync_out(s_vso), .de_out(s_de),
        .r_out(s_r), .g_out(s_g), .b_out(s_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset  = 1'b0;
        pix_en = 1'b1;
        tick(3);
        chk("rst d_x", d_x, 0);            chk("rst d_y", d_y, 0);
        chk("rst d_valid", d_valid, 0);    chk("rst d_fs", d_fs, 0);
        chk("rst d_de", d_de, 0);          chk("rst d_r", d_r, 0);
        chk("rst d_hso", d_hso, 0);        chk("rst d_vso", d_vso, 0);
        chk("rst d_vsync", d_vsync, 0);
        chk("rst s_hso", s_hso, 1);        chk("rst s_vso", s_vso, 1);
        chk("rst s_vsync", s_vsync, 1);    chk("rst s_b", s_b, 0);

        reset = 1'b1;
        cnt_d_valid = 0; cnt_d_hs = 0; cnt_s_fs = 0; cnt_s_vs = 0;
        for (int k = 1; k <= 1700; k++) begin
            tick(1);
            if (k <= 1688) begin
                cnt_d_valid += int'(d_valid);
                cnt_d_hs    += int'(d_hso);
            end
            cnt_s_fs += int'(s_fs);
            cnt_s_vs += int'(!s_vsync);
            case (k)
                1: begin
                    chk("k1 d_x", d_x, 0);   chk("k1 d_y", d_y, 0);
                    chk("k1 d_valid", d_valid, 1); chk("k1 d_fs", d_fs, 1);
                    chk("k1 s_fs", s_fs, 1); chk("k1 s_valid", s_valid, 1);
                    chk("k1 s_vsync", s_vsync, 1);
                end
                2:  begin chk("k2 d_x", d_x, 1); chk("k2 d_fs", d_fs, 0); end
                3:  begin chk("k3 d_de", d_de, 0); chk("k3 d_r", d_r, 0); end
                4: begin
                    chk("k4 d_de", d_de, 1); chk("k4 d_r", d_r, 0);
                    chk("k4 d_g", d_g, 8'hFF); chk("k4 d_b", d_b, 8'hA5);
                    chk("k4 s_de", s_de, 0); chk("k4 s_r", s_r, 0);
                end
                5:  begin chk("k5 s_de", s_de, 1); chk("k5 s_r", s_r, 8'h3C); end
                11: begin chk("k11 s_de", s_de, 0); chk("k11 s_r", s_r, 0); end
                12: chk("k12 s_hso", s_hso, 1);
                13: chk("k13 s_hso", s_hso, 0);
                16: chk("k16 s_hso", s_hso, 1);
                40: begin chk("k40 s_y", s_y, 3); chk("k40 s_x", s_x, 0); chk("k40 s_valid", s_valid, 1); end
                53: begin chk("k53 s_y", s_y, 0); chk("k53 s_valid", s_valid, 0); end
                65: chk("k65 s_vsync", s_vsync, 1);
                66: begin chk("k66 s_vsync", s_vsync, 0); chk("k66 s_y", s_y, 0); chk("k66 s_valid", s_valid, 0); end
                69: chk("k69 s_vso", s_vso, 1);
                70: chk("k70 s_vso", s_vso, 0);
                105: begin chk("k105 s_fs", s_fs, 1); chk("k105 s_x", s_x, 0); chk("k105 s_y", s_y, 0); end
                300: begin chk("k300 d_x", d_x, 299); chk("k300 d_r", d_r, 8'h28); chk("k300 d_g", d_g, 8'hD7); end
                1000: chk("k1000 d_vso", d_vso, 0);
                1280: begin chk("k1280 d_x", d_x, 1279); chk("k1280 d_valid", d_valid, 1); end
                1281: begin chk("k1281 d_x", d_x, 0); chk("k1281 d_valid", d_valid, 0); end
                1283: begin chk("k1283 d_de", d_de, 1); chk("k1283 d_r", d_r, 8'hFF); end
                1284: begin
                    chk("k1284 d_de", d_de, 0); chk("k1284 d_r", d_r, 0);
                    chk("k1284 d_g", d_g, 0);   chk("k1284 d_b", d_b, 0);
                end
                1331: chk("k1331 d_hso", d_hso, 0);
                1332: chk("k1332 d_hso", d_hso, 1);
                1443: chk("k1443 d_hso", d_hso, 1);
                1444: chk("k1444 d_hso", d_hso, 0);
                1689: begin
                    chk("k1689 d_x", d_x, 0); chk("k1689 d_y", d_y, 1);
                    chk("k1689 d_valid", d_valid, 1); chk("k1689 d_fs", d_fs, 0);
                end
                default: ;
            endcase
        end
        chk("line valid count", cnt_d_valid, 1280);
        chk("line hsync count", cnt_d_hs, 112);
        chk("s frame_start count", cnt_s_fs, 17);
        chk("s vsync count", cnt_s_vs, 416);

        // Stall behaviour around a small-frame start
        tick(69);
        chk("st0 s_fs", s_fs, 1);  chk("st0 d_x", d_x, 80);
        pix_en = 1'b0; tick(1);
        chk("st1 s_fs hold", s_fs, 1); chk("st1 s_x", s_x, 0); chk("st1 d_x", d_x, 80);
        pix_en = 1'b1; tick(1);
        chk("st2 s_fs", s_fs, 0); chk("st2 s_x", s_x, 1); chk("st2 d_x", d_x, 81);
        pix_en = 1'b1; tick(1);
        pix_en = 1'b0; tick(1);
        pix_en = 1'b1; tick(1);
        pix_en = 1'b0; tick(1);
        chk("toggle d_x", d_x, 83);

        // Asynchronous reset in the middle of a frame
        pix_en = 1'b1; tick(67);
        chk("pre d_x", d_x, 150);  chk("pre d_de", d_de, 1);
        chk("pre d_r", d_r, 8'h93); chk("pre s_vsync", s_vsync, 0);
        #2 reset = 1'b0;
        #1;
        chk("arst d_x", d_x, 0);        chk("arst d_y", d_y, 0);
        chk("arst d_valid", d_valid, 0); chk("arst d_de", d_de, 0);
        chk("arst d_r", d_r, 0);        chk("arst s_vsync", s_vsync, 1);
        chk("arst s_y", s_y, 0);
        @(negedge clk);
        chk("arst hold d_x", d_x, 0);
        reset = 1'b1; tick(1);
        chk("rel d_x", d_x, 0);   chk("rel d_y", d_y, 0);
        chk("rel d_valid", d_valid, 1); chk("rel d_fs", d_fs, 1);
        chk("rel s_fs", s_fs, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/display_timing_gen.md
DISPLAY_TIMING_GEN -- requirements
Module: display_timing_gen

Interface
REQ-001 Parameters SHALL be: H_ACTIVE 1280, H_FP 48, H_SYNC 112, H_BP 248, V_ACTIVE 1024, V_FP 1, V_SYNC 3, V_BP 38, HS_POL 1, VS_POL 1, PIPE 2, each given as name, default and meaning.
- H_ACTIVE, H_FP, H_SYNC, H_BP: horizontal active, front porch, sync and back porch lengths in pixels.
- V_ACTIVE, V_FP, V_SYNC, V_BP: the same four lengths vertically, in lines.
- HS_POL, VS_POL: asserted level of the hsync and vsync pulses.
- PIPE: pixel latency of the downstream renderer, in enabled cycles, range 1..8.
REQ-002 clk  in  1  single clock for all logic.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 pix_en  in  1  pixel-rate enable; all state advances only on clk edges where pix_en=1.
REQ-005 x  out  11  current pixel column, 0..H_ACTIVE-1 when valid, else 0.
REQ-006 y  out  10  current pixel row, 0..V_ACTIVE-1 when valid, else 0.
REQ-007 valid  out  1  current position is inside the active region.
REQ-008 vsync  out  1  undelayed vertical sync, at VS_POL level when asserted; drives the capture-idle logic.
REQ-009 frame_start  out  1  one-enabled-cycle pulse at position (0,0).
REQ-010 r_in, g_in, b_in  in  8 each  renderer colour for the pixel issued PIPE enabled cycles earlier.
REQ-011 hsync_out, vsync_out, de_out  out  1 each  sync and data-enable signals delayed to align with the colour outputs.
REQ-012 r_out, g_out, b_out  out  8 each  aligned colour, forced to 0 when de_out=0.

Function
REQ-013 h_cnt (11b) SHALL count 0..H_TOTAL-1 and wrap; H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 1688.
REQ-014 v_cnt (11b) SHALL increment only when h_cnt wraps, count 0..V_TOTAL-1 and wrap; V_TOTAL = 1066.
REQ-015 All outputs SHALL be registered, and x, y, valid, vsync and frame_start SHALL describe the same (h_cnt, v_cnt) position in the same cycle.
REQ-016 valid SHALL be 1 iff h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
REQ-017 The internal hsync SHALL be asserted iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, i.e. h_cnt 1328..1439 at defaults.
REQ-018 vsync SHALL be asserted iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, i.e. v_cnt 1025..1027 at defaults; vsync timing is whole lines, aligned to h_cnt=0.
REQ-019 frame_start SHALL be 1 iff h_cnt=0 and v_cnt=0.
REQ-020 When pix_en=0, every register SHALL hold, and frame_start SHALL remain at its held value.
REQ-021 Delay line: hsync, vsync and valid SHALL pass through PIPE registers advanced on pix_en, producing tapped signals hs_d, vs_d and de_d.
REQ-022 Output stage, on each enabled edge:
- hsync_out <= hs_d, vsync_out <= vs_d, de_out <= de_d.
- {r_out, g_out, b_out} <= de_d ? {r_in, g_in, b_in} : 0.
REQ-023 Total latency from x/y/valid to the matching de_out/r_out SHALL be PIPE+1 enabled cycles.
REQ-024 Sync levels SHALL be XORed with the polarity parameters only at the output registers, so the internal logic is active-high.
REQ-025 Parameter sums SHALL fit in 11 bits, with H_TOTAL <= 2047 and V_TOTAL <= 2047.

Reset
REQ-026 While reset=0, counters SHALL be h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1.
REQ-027 While reset=0, x=0, y=0, valid=0, frame_start=0 and de_out=0.
REQ-028 While reset=0, all delay-line stages and r/g/b_out SHALL be 0.
REQ-029 While reset=0, all syncs SHALL be at their deasserted level (~HS_POL, ~VS_POL).
REQ-030 The first enabled edge after reset release SHALL give (0,0), valid=1 and frame_start=1.
REQ-031 Reset asserted mid-frame SHALL reach the reset state immediately (asynchronously), with no partial-line completion.

Verification
REQ-032 Defaults, pix_en=1, release reset -> first enabled edge: x=0, y=0, valid=1, frame_start=1; frame_start recurs exactly every 1688*1066 = 1,799,408 cycles.
REQ-033 Defaults, line 0 -> valid high for exactly 1280 cycles; internal hsync asserted for h_cnt 1328..1439; x wraps 1279->0 only through the blanking interval.
REQ-034 Defaults -> vsync asserted for v_cnt 1025..1027 (3*1688 cycles), starting at h_cnt=0; y stays 0 while valid=0.
REQ-035 PIPE=2, r_in = x[7:0] driven from a 2-enabled-cycle delay of x -> r_out equals the low byte of the column, 3 enabled cycles after x; r_out=0 whenever de_out=0.
REQ-036 pix_en toggled 1,0,1,0 -> counters advance once per two clocks and frame_start holds high across the idle cycle; reset pulsed at v_cnt=500 -> outputs take reset values without waiting for a clock edge.
